// File: rtl/vga_rect_painter.sv
// Rectangle-fill / full-screen-clear frame-buffer writer, one pixel write per clock in raster order.
// Latency: first write one cycle after command acceptance; done one cycle after the last write.
// Backpressure: cmd_ready only in IDLE (no queueing); stall_i freezes the raster walk for that cycle.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o  command handshake
//   cmd_clear_i                fill whole screen, coordinates ignored
//   cmd_x0_i, cmd_x1_i         inclusive column bounds (10 bit)
//   cmd_y0_i, cmd_y1_i         inclusive row bounds (9 bit)
//   cmd_color_i                RGB888 fill value
//   stall_i                    frame-buffer write port unavailable this cycle
//   wr_en_o, wr_addr_o, wr_data_o   pixel write port, addr = {x[9:0], y[8:0]}
//   busy_o, done_o             command in progress / one-cycle completion pulse
//   pix_count_o                pixels written for the current or most recent command
module vga_rect_painter #(
    parameter int H_MAX = 640,
    parameter int V_MAX = 480
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_clear_i,
    input  logic [9:0]  cmd_x0_i,
    input  logic [9:0]  cmd_x1_i,
    input  logic [8:0]  cmd_y0_i,
    input  logic [8:0]  cmd_y1_i,
    input  logic [23:0] cmd_color_i,
    input  logic        stall_i,
    output logic        wr_en_o,
    output logic [18:0] wr_addr_o,
    output logic [23:0] wr_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [18:0] pix_count_o
);

    localparam logic [9:0] X_LAST = 10'(H_MAX - 1);
    localparam logic [8:0] Y_LAST = 9'(V_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAINT,
        ST_DONE
    } state_e;

    state_e state_q, state_d;

    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [9:0]  x0_q, x0_d;
    logic [9:0]  x1_q, x1_d;
    logic [8:0]  y1_q, y1_d;
    logic [23:0] color_q, color_d;
    logic [18:0] pix_q, pix_d;

    // Effective (clipped) bounds of the command on the input pins.
    logic [9:0] eff_x0, eff_x1;
    logic [8:0] eff_y0, eff_y1;
    logic       cmd_empty;
    logic       accept;
    logic       step;
    logic       last_col;
    logic       last_pix;

    always_comb begin
        eff_x0 = cmd_x0_i;
        eff_y0 = cmd_y0_i;
        eff_x1 = (cmd_x1_i > X_LAST) ? X_LAST : cmd_x1_i;
        eff_y1 = (cmd_y1_i > Y_LAST) ? Y_LAST : cmd_y1_i;
        if (cmd_clear_i) begin
            eff_x0 = '0;
            eff_y0 = '0;
            eff_x1 = X_LAST;
            eff_y1 = Y_LAST;
        end
    end

    // Clipping x1/y1 already folds x0 >= H_MAX and y0 >= V_MAX into this test.
    assign cmd_empty = (eff_x0 > eff_x1) || (eff_y0 > eff_y1);
    assign accept    = (state_q == ST_IDLE) && cmd_valid_i;
    assign step      = (state_q == ST_PAINT) && !stall_i;
    assign last_col  = (x_q == x1_q);
    assign last_pix  = last_col && (y_q == y1_q);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = cmd_empty ? ST_DONE : ST_PAINT;
                end
            end
            ST_PAINT: begin
                if (step && last_pix) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state; wr_en also gated by the stall input.
    always_comb begin
        cmd_ready_o = (state_q == ST_IDLE);
        busy_o      = (state_q != ST_IDLE);
        done_o      = (state_q == ST_DONE);
        wr_en_o     = step;
        wr_addr_o   = {x_q, y_q};
        wr_data_o   = color_q;
        pix_count_o = pix_q;
    end

    // Raster walker and command latch
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        color_d = color_q;
        pix_d   = pix_q;
        if (accept) begin
            x_d     = eff_x0;
            y_d     = eff_y0;
            x0_d    = eff_x0;
            x1_d    = eff_x1;
            y1_d    = eff_y1;
            color_d = cmd_color_i;
            pix_d   = '0;
        end else if (step) begin
            pix_d = pix_q + 19'd1;
            // On the final pixel the position is left alone so the address
            // stays on the last written location after the command ends.
            if (!last_pix) begin
                if (last_col) begin
                    x_d = x0_q;
                    y_d = y_q + 9'd1;
                end else begin
                    x_d = x_q + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q     <= '0;
            y_q     <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            pix_q   <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            color_q <= color_d;
            pix_q   <= pix_d;
        end
    end

endmodule

// File: tb/tb_vga_rect_painter.sv
// Self-checking bench for vga_rect_painter, run on a reduced 40x30 screen so
// that full-screen clears stay short.
module tb_vga_rect_painter;

    localparam int H = 40;
    localparam int V = 30;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_clear = 1'b0;
    logic [9:0]  cmd_x0 = '0;
    logic [9:0]  cmd_x1 = '0;
    logic [8:0]  cmd_y0 = '0;
    logic [8:0]  cmd_y1 = '0;
    logic [23:0] cmd_color = '0;
    logic        stall = 1'b0;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [23:0] wr_data;
    logic        busy;
    logic        done;
    logic [18:0] pix_count;

    int checks = 0;
    int failures = 0;
    int exp_q[$];

    vga_rect_painter #(.H_MAX(H), .V_MAX(V)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_clear_i (cmd_clear),
        .cmd_x0_i    (cmd_x0),
        .cmd_x1_i    (cmd_x1),
        .cmd_y0_i    (cmd_y0),
        .cmd_y1_i    (cmd_y1),
        .cmd_color_i (cmd_color),
        .stall_i     (stall),
        .wr_en_o     (wr_en),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data),
        .busy_o      (busy),
        .done_o      (done),
        .pix_count_o (pix_count)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) at negedges until the block is ready for a command.
    task automatic wait_ready(input string tag);
        @(negedge clk_i);
        for (int k = 0; k < 50 && !cmd_ready; k++) @(negedge clk_i);
        chk({tag, " ready"}, cmd_ready, 1);
    endtask

    // Drive one command and check every write, the done timing and pix_count
    // against a pixel list built directly from the rectangle definition.
    // exp_done < 0 means "N + 1 + stalled paint cycles".
    task automatic run_cmd(input string tag, input bit clr, input int ax0, input int ax1,
                           input int ay0, input int ay1, input logic [23:0] col,
                           input int stall_pct, input int st_lo, input int st_hi,
                           input int exp_done);
        int ex0, ex1, ey0, ey1, n, cyc, wi, stalls, limit, exp_cyc;
        bit st, fin;
        if (clr) begin
            ex0 = 0; ex1 = H - 1; ey0 = 0; ey1 = V - 1;
        end else begin
            ex0 = ax0; ey0 = ay0;
            ex1 = (ax1 > H - 1) ? H - 1 : ax1;
            ey1 = (ay1 > V - 1) ? V - 1 : ay1;
        end
        exp_q.delete();
        for (int y = ey0; y <= ey1; y++)
            for (int x = ex0; x <= ex1; x++)
                exp_q.push_back(x * 512 + y);
        n = exp_q.size();

        wait_ready(tag);
        cmd_valid = 1'b1;
        cmd_clear = clr;
        cmd_x0 = 10'(ax0); cmd_x1 = 10'(ax1);
        cmd_y0 = 9'(ay0);  cmd_y1 = 9'(ay1);
        cmd_color = col;
        @(posedge clk_i);
        #1;
        // Garbage on the command pins while busy must be ignored.
        cmd_valid = 1'b0;
        cmd_clear = 1'($urandom);
        cmd_x0 = 10'($urandom); cmd_x1 = 10'($urandom);
        cmd_y0 = 9'($urandom);  cmd_y1 = 9'($urandom);
        cmd_color = 24'($urandom);

        cyc = 0; wi = 0; stalls = 0; fin = 0;
        limit = 4 * n + 20;
        while (!fin) begin
            st = ((cyc + 1) >= st_lo && (cyc + 1) <= st_hi) ||
                 (int'($urandom_range(99)) < stall_pct);
            stall = st;
            @(negedge clk_i);
            cyc++;
            chk({tag, " busy"}, busy, 1);
            chk({tag, " ready low"}, cmd_ready, 0);
            if (st && wi < n) begin
                stalls++;
                chk({tag, " stall wr_en"}, wr_en, 0);
                chk({tag, " stall addr"}, wr_addr, exp_q[wi]);
            end
            if (wr_en) begin
                if (wi < n) begin
                    chk({tag, " addr"}, wr_addr, exp_q[wi]);
                    chk({tag, " data"}, wr_data, col);
                end else begin
                    chk({tag, " extra write"}, wi + 1, n);
                end
                wi++;
            end
            if (done) begin
                exp_cyc = (exp_done >= 0) ? exp_done : n + 1 + stalls;
                chk({tag, " done cycle"}, cyc, exp_cyc);
                chk({tag, " writes"}, wi, n);
                chk({tag, " pix_count"}, pix_count, n);
                fin = 1;
            end else if (cyc > limit) begin
                chk({tag, " timeout"}, cyc, n + 1 + stalls);
                fin = 1;
            end else begin
                @(posedge clk_i);
                #1;
            end
        end
        @(posedge clk_i);
        #1;
        stall = 1'b0;
        @(negedge clk_i);
        chk({tag, " ready after"}, cmd_ready, 1);
        chk({tag, " idle busy"}, busy, 0);
        chk({tag, " idle done"}, done, 0);
        chk({tag, " pix hold"}, pix_count, n);
    endtask

    task automatic back_to_back();
        wait_ready("b2b");
        cmd_valid = 1'b1; cmd_clear = 1'b0;
        cmd_x0 = 10'd10; cmd_x1 = 10'd10; cmd_y0 = 9'd10; cmd_y1 = 9'd10;
        cmd_color = 24'h123456;
        @(posedge clk_i);
        #1;
        cmd_x0 = 10'd20; cmd_x1 = 10'd21; cmd_y0 = 9'd3; cmd_y1 = 9'd3;
        cmd_color = 24'hABCDEF;
        @(negedge clk_i);  // cycle 1
        chk("b2b c1 wr_en", wr_en, 1);
        chk("b2b c1 addr", wr_addr, 10 * 512 + 10);
        chk("b2b c1 data", wr_data, 24'h123456);
        chk("b2b c1 ready", cmd_ready, 0);
        @(negedge clk_i);  // cycle 2
        chk("b2b c2 done", done, 1);
        chk("b2b c2 ready", cmd_ready, 0);
        chk("b2b c2 wr_en", wr_en, 0);
        @(negedge clk_i);  // cycle 3
        chk("b2b c3 ready", cmd_ready, 1);
        chk("b2b c3 busy", busy, 0);
        @(posedge clk_i);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk_i);
        chk("b2b B1 wr_en", wr_en, 1);
        chk("b2b B1 addr", wr_addr, 20 * 512 + 3);
        chk("b2b B1 data", wr_data, 24'hABCDEF);
        @(negedge clk_i);
        chk("b2b B2 addr", wr_addr, 21 * 512 + 3);
        @(negedge clk_i);
        chk("b2b B done", done, 1);
        chk("b2b B pix", pix_count, 2);
    endtask

    task automatic reset_mid();
        int wi, bad;
        wait_ready("rst");
        cmd_valid = 1'b1; cmd_clear = 1'b0;
        cmd_x0 = 10'd3; cmd_x1 = 10'd12; cmd_y0 = 9'd4; cmd_y1 = 9'd13;
        cmd_color = 24'h00FF00;
        @(posedge clk_i);
        #1;
        cmd_valid = 1'b0;
        wi = 0;
        for (int k = 0; k < 10 && wi < 3; k++) begin
            @(negedge clk_i);
            if (wr_en) wi++;
        end
        chk("rst 3rd write seen", wi, 3);
        chk("rst 3rd addr", wr_addr, 5 * 512 + 4);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("rst async wr_en", wr_en, 0);
        chk("rst async busy", busy, 0);
        chk("rst async done", done, 0);
        chk("rst async ready", cmd_ready, 1);
        chk("rst async addr", wr_addr, 0);
        chk("rst async pix", pix_count, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        bad = 0;
        repeat (15) begin
            @(negedge clk_i);
            if (wr_en || done || !cmd_ready) bad++;
        end
        chk("rst after release quiet", bad, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int ax0, ax1, ay0, ay1, pct;
        bit clr;
        #2;
        chk("reset ready", cmd_ready, 1);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset wr_en", wr_en, 0);
        chk("reset addr", wr_addr, 0);
        chk("reset data", wr_data, 0);
        chk("reset pix", pix_count, 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        run_cmd("single", 0, 5, 5, 7, 7, 24'hFF0000, 0, 0, -1, 2);
        run_cmd("rect3x2", 0, 2, 4, 1, 2, 24'h0000FF, 0, 0, -1, 7);
        run_cmd("clip", 0, H - 2, 1000, V - 2, 500, 24'h00FFFF, 0, 0, -1, 5);
        run_cmd("empty x0 off", 0, 700, 800, 0, 10, 24'h111111, 0, 0, -1, 1);
        run_cmd("empty x0>x1", 0, 9, 3, 0, 0, 24'h222222, 0, 0, -1, 1);
        run_cmd("clear", 1, 7, 3, 9, 1, 24'h000000, 0, 0, -1, H * V + 1);
        run_cmd("stall", 0, 2, 4, 1, 2, 24'h5A5A5A, 0, 2, 3, 9);
        back_to_back();
        reset_mid();

        for (int i = 0; i < 30; i++) begin
            clr = ($urandom_range(14) == 0);
            ax0 = ($urandom_range(7) == 0) ? int'($urandom_range(1023)) : int'($urandom_range(H + 3));
            ay0 = ($urandom_range(7) == 0) ? int'($urandom_range(511))  : int'($urandom_range(V + 3));
            case ($urandom_range(7))
                0:       ax1 = 1023;
                1:       ax1 = int'($urandom_range(1023));
                default: ax1 = (ax0 + int'($urandom_range(9))) & 1023;
            endcase
            case ($urandom_range(7))
                0:       ay1 = 511;
                1:       ay1 = int'($urandom_range(511));
                default: ay1 = (ay0 + int'($urandom_range(6))) & 511;
            endcase
            pct = ($urandom_range(1) == 1) ? 25 : 0;
            run_cmd("rand", clr, ax0, ax1, ay0, ay1, 24'($urandom) | 24'h1, pct, 0, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_rect_painter.md
# vga_rect_painter

Command-driven frame-buffer writer on the upstream side of the video memory that feeds `vga_ctrl`. It accepts rectangle-fill or full-screen-clear commands over a valid/ready handshake and emits one pixel write per clock into the frame buffer's write port. It uses the same `{h, v}` address packing the read side uses: 10-bit column, 9-bit row, 19-bit address. It reports `busy` and a one-cycle `done` pulse per command.

## Interface
- `H_MAX`, 640, visible columns; valid x is 0..H_MAX-1
- `V_MAX`, 480, visible rows; valid y is 0..V_MAX-1
- `clk`  in  1  single clock for all state
- `rst`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  block can accept a command
- `cmd_clear`  in  1  1 = fill the whole screen; coordinates are ignored
- `cmd_x0`, `cmd_x1`  in  10  inclusive column bounds
- `cmd_y0`, `cmd_y1`  in  9  inclusive row bounds
- `cmd_color`  in  24  RGB888 fill value
- `stall`  in  1  frame-buffer port unavailable this cycle
- `wr_en`  out  1  pixel write strobe
- `wr_addr`  out  19  `{x[9:0], y[8:0]}`
- `wr_data`  out  24  pixel colour
- `busy`  out  1  command in progress
- `done`  out  1  one-cycle completion pulse
- `pix_count`  out  19  pixels written for the current or most recent command

## Operation
- States are IDLE, PAINT and DONE. The reset state is IDLE.
- **IDLE**
  - `cmd_ready` = 1.
  - A command is accepted on a cycle with `cmd_valid & cmd_ready`.
  - On acceptance, latch the colour and the effective bounds.
  - Clear pixel counter to 0.
  - Load x = x0 and y = y0.
- **Effective bounds**
  - `cmd_clear` = 1: bounds are (0, 0) to (H_MAX-1, V_MAX-1).
  - Otherwise, clip x1 to min(x1, H_MAX-1) and y1 to min(y1, V_MAX-1).
  - A command is empty if x0 > clipped x1 or y0 > clipped y1. This includes x0 ≥ H_MAX and y0 ≥ V_MAX.
  - An empty command goes IDLE -> DONE and performs no writes.
  - A non-empty command goes IDLE -> PAINT.
- **PAINT**
  - When `stall` = 0:
    - `wr_en` = 1, `wr_addr` = {x, y}, `wr_data` = latched colour.
    - The pixel counter increments.
  - Raster order:
    - x increments toward x1.
    - At x == x1, x reloads x0 and y increments.
  - After the write at (x1, y1), the state moves to DONE.
  - When `stall` = 1:
    - `wr_en` = 0.
    - x, y, the counter and the state hold.
    - `wr_addr` and `wr_data` hold their values.
- **DONE**
  - `done` = 1 for exactly one cycle and `cmd_ready` = 0.
  - The next state is IDLE.
- `busy` = 1 in PAINT and DONE, 0 in IDLE.
- `cmd_ready` = 1 only in IDLE, so `busy` and `cmd_ready` are never both 1.
- Command inputs are ignored while `busy`; there is no queueing.
- Width rules:
  - Coordinate compares are unsigned at full port width.
  - `pix_count` is 19 bits; the maximum is 307200 (0x4B000), so it never wraps.
- `pix_count` holds its value after DONE until the next acceptance.

## Timing
- Reset values, asserted immediately on `rst` low without waiting for a clock edge:
  - state = IDLE
  - `cmd_ready` = 1
  - `busy` = 0, `done` = 0, `wr_en` = 0
  - `wr_addr` = 0, `wr_data` = 0, `pix_count` = 0
- Reset mid-command:
  - Writing stops at once.
  - The latched command is discarded and no `done` is produced.
- The acceptance edge is cycle 0. The first write is presented in cycle 1.
- Without stalls, a command of N pixels has:
  - writes in cycles 1..N,
  - `done` in cycle N+1,
  - `cmd_ready` = 1 again in cycle N+2.
- An empty command gives `done` in cycle 1 and `cmd_ready` in cycle 2.
- Each stalled PAINT cycle adds exactly one cycle. `stall` is ignored in IDLE and DONE.
- All outputs are registered, or decoded only from registered state. There is no combinational path from a `cmd_*` input to any output.
- The write port is consumed on any rising edge where `wr_en` = 1; no acknowledge is expected.

## Test plan
- **Single pixel.** x0=x1=5, y0=y1=7, colour 0xFF0000.
  - Exactly 1 write: addr {10'd5, 9'd7} = 0x00A07, data 0xFF0000.
  - `done` in cycle 2; `pix_count` = 1.
- **3x2 rectangle.** (2,1)-(4,2).
  - Writes in order (2,1) (3,1) (4,1) (2,2) (3,2) (4,2) in cycles 1..6.
  - `done` in cycle 7; `pix_count` = 6.
- **Clipping and empty commands.**
  - (638,478)-(1000,500): 4 writes, (638,478) (639,478) (638,479) (639,479).
  - (700,0)-(800,10): 0 writes, `done` in cycle 1.
  - x0=9, x1=3: 0 writes, `done` in cycle 1.
- **Clear.** `cmd_clear`=1, colour 0x000000.
  - 307200 writes; first addr 0x00000, last {639,479} = 0x4FFDF.
  - `done` in cycle 307201; `pix_count` = 0x4B000.
- **Stall and back-to-back.**
  - 3x2 command with `stall` high in cycles 2-3: `wr_en` = 0 in those cycles, address held, `done` in cycle 9.
  - `cmd_valid` held high throughout: the second command is accepted only in the cycle after `done`.
- **Reset mid-operation.**
  - Assert `rst` low during the 3rd write of a 10x10 command: `wr_en`, `busy` and `done` go to 0 asynchronously.
  - After release: `cmd_ready` = 1, no further writes and no `done` pulse.
